mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of cycles the SRAM strobe (OE_N or WE_N) is held low per access; legal range 1..15.
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-004 Req_Rd  in  1  read request from ISDU; level, sampled only in IDLE.
REQ-005 Req_Wr  in  1  write request from ISDU; level, sampled only in IDLE.
REQ-006 Addr  in  16  MAR value; latched on request acceptance.
REQ-007 Wdata  in  16  MDR value; latched on write acceptance.
REQ-008 Rdata  out  16  registered read data to MDR.
REQ-009 Busy  out  1  high in every state except IDLE.
REQ-010 Done  out  1  one-cycle pulse when an access completes.
REQ-011 Rd_Valid  out  1  one-cycle pulse, coincident with Done, for read accesses only.
REQ-012 SRAM_ADDR  out  20  {4'b0, latched Addr}.
REQ-013 SRAM_DOUT  out  16  latched write data; SRAM_DIN  in  16  SRAM read data.
REQ-014 SRAM_DRIVE  out  1  tristate enable for the SRAM data pins (1 = drive SRAM_DOUT).
REQ-015 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.

Function
REQ-016 FSM states SHALL be IDLE, RD_SETUP, RD_WAIT, RD_CAPTURE, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-017 In IDLE, Req_Wr=1 SHALL go to WR_SETUP; otherwise Req_Rd=1 SHALL go to RD_SETUP; otherwise stay (write wins a simultaneous request).
REQ-018 On acceptance, Addr (and Wdata for writes) SHALL be registered and held constant until the next acceptance.
REQ-019 Requests asserted outside IDLE SHALL be ignored, not queued.
REQ-020 RD_SETUP: CE_N=0, OE_N=1; the next state SHALL be RD_WAIT with the wait counter loaded to WAIT_CYCLES.
REQ-021 RD_WAIT: CE_N=0, OE_N=0; the state SHALL be held for exactly WAIT_CYCLES cycles, then go to RD_CAPTURE.
REQ-022 RD_CAPTURE: CE_N=0, OE_N=0; SRAM_DIN SHALL be registered into Rdata at the end of the cycle; the next state SHALL be DONE.
REQ-023 WR_SETUP: CE_N=0, WE_N=1, SRAM_DRIVE=1; the next state SHALL be WR_PULSE with the counter loaded.
REQ-024 WR_PULSE: CE_N=0, WE_N=0, SRAM_DRIVE=1; the state SHALL be held for exactly WAIT_CYCLES cycles, then go to WR_HOLD.
REQ-025 WR_HOLD: CE_N=0, WE_N=1, SRAM_DRIVE=1; the next state SHALL be DONE.
REQ-026 DONE: all strobes inactive, Done=1, Rd_Valid=1 if the access was a read; the next state SHALL be IDLE unconditionally.
REQ-027 Latency: with acceptance in cycle N, Done SHALL be high in cycle N+WAIT_CYCLES+3 for both reads and writes.
REQ-028 OE_N and WE_N SHALL never be low in the same cycle; SRAM_DRIVE SHALL be 0 whenever OE_N=0.
REQ-029 SRAM_UB_N and SRAM_LB_N SHALL equal SRAM_CE_N (word access only).
REQ-030 Rdata SHALL hold its value across writes and idle cycles and change only in RD_CAPTURE.
REQ-031 A new request present in the IDLE cycle that follows DONE SHALL be accepted (back-to-back spacing of WAIT_CYCLES+4 cycles).
REQ-032 All outputs SHALL be driven from registers or from decoding the registered state only, with no combinational path from Req_* to the SRAM pins.

Reset
REQ-033 Reset_n=0 SHALL immediately force IDLE, regardless of any access in progress.
REQ-034 Reset values: Rdata=0, latched Addr/Wdata=0, counter=0, Busy=Done=Rd_Valid=0, SRAM_DRIVE=0, all *_N strobes=1.
REQ-035 An access interrupted by reset SHALL NOT produce Done, and SHALL NOT be resumed.

Structure
REQ-036 State enum, WORD_W=16 and SRAM_ADDR_W=20 SHALL live in the shared package slc3_pkg.
REQ-037 The block SHALL be a single module; no sub-module is required (the wait counter is inline).

Verification
REQ-038 With WAIT_CYCLES=2, Req_Rd=1 and Addr=16'h1234 accepted in cycle 0, SRAM_DIN=16'hBEEF -> SRAM_ADDR=20'h01234, OE_N low in cycles 2-4, Rdata=16'hBEEF, Done and Rd_Valid high in cycle 5 only.
REQ-039 With Req_Wr=1, Addr=16'h00FF and Wdata=16'hA5A5 -> WE_N low in exactly cycles 2-3, SRAM_DRIVE high in cycles 1-4, Done in cycle 5, Rd_Valid=0, Rdata unchanged.
REQ-040 With Req_Rd and Req_Wr both high in IDLE -> a write sequence is performed and OE_N stays 1 throughout.
REQ-041 Reset_n pulsed low during WR_PULSE -> WE_N=1, CE_N=1, SRAM_DRIVE=0 within the same cycle, no Done, Busy=0.
REQ-042 Req_Rd held high continuously with WAIT_CYCLES=1 -> a read is accepted every 5 cycles, and no request is accepted while Busy=1.
REQ-043 Sweep WAIT_CYCLES=1 and 15 -> strobe low for exactly 1 and 15 cycles, and Done at N+4 and N+18 respectively.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: word/address widths and the SRAM access FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package slc3_pkg;

  localparam int WORD_W      = 16;
  localparam int SRAM_ADDR_W = 20;
  localparam int WCNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_SETUP   = 3'd1,
    RD_WAIT    = 3'd2,
    RD_CAPTURE = 3'd3,
    WR_SETUP   = 3'd4,
    WR_PULSE   = 3'd5,
    WR_HOLD    = 3'd6,
    DONE       = 3'd7
  } mac_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Purpose: sequences one 16-bit asynchronous SRAM read or write per ISDU request.
// Latency: Done/Rd_Valid pulse WAIT_CYCLES+3 cycles after acceptance; next accept one cycle later.
// Backpressure: Busy high outside IDLE; requests seen while busy are dropped, not queued.
module mem_access_ctrl
  import slc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Req_Rd,
  input  logic                   Req_Wr,
  input  logic [WORD_W-1:0]      Addr,
  input  logic [WORD_W-1:0]      Wdata,
  output logic [WORD_W-1:0]      Rdata,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Rd_Valid,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [WORD_W-1:0]      SRAM_DOUT,
  input  logic [WORD_W-1:0]      SRAM_DIN,
  output logic                   SRAM_DRIVE,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);

  mac_state_t        state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
  logic              acc_rd_q;
  logic              accept;

  // A request is only ever looked at while idle; write wins a tie.
  assign accept = (state_q == IDLE) && (Req_Wr || Req_Rd);

  // State and wait-counter registers; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter is loaded on leaving SETUP and counts the strobe-low cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Req_Wr)      state_d = WR_SETUP;
        else if (Req_Rd) state_d = RD_SETUP;
      end
      RD_SETUP: begin
        state_d = RD_WAIT;
        cnt_d   = WAIT_LD;
      end
      RD_WAIT: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = RD_CAPTURE;
      end
      RD_CAPTURE: state_d = DONE;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WAIT_LD;
      end
      WR_PULSE: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = WR_HOLD;
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, write data and access type are captured at acceptance and held until the next one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      acc_rd_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= Addr;
      acc_rd_q <= !Req_Wr;
      if (Req_Wr) wdata_q <= Wdata;
    end
  end

  // Read data is sampled only at the end of the capture cycle, so it survives writes and idle time.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdata_q <= '0;
    end else if (state_q == RD_CAPTURE) begin
      rdata_q <= SRAM_DIN;
    end
  end

  // Pin strobes decoded purely from the registered state, so no request can reach the SRAM combinationally.
  always_comb begin
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_DRIVE = 1'b0;
    Done       = 1'b0;
    Rd_Valid   = 1'b0;
    case (state_q)
      RD_SETUP:   SRAM_CE_N = 1'b0;
      RD_WAIT,
      RD_CAPTURE: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      WR_SETUP,
      WR_HOLD: begin
        SRAM_CE_N  = 1'b0;
        SRAM_DRIVE = 1'b1;
      end
      WR_PULSE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_WE_N  = 1'b0;
        SRAM_DRIVE = 1'b1;
      end
      DONE: begin
        Done     = 1'b1;
        Rd_Valid = acc_rd_q;
      end
      default: ;
    endcase
  end

  assign Busy      = (state_q != IDLE);
  assign SRAM_UB_N = SRAM_CE_N;
  assign SRAM_LB_N = SRAM_CE_N;
  assign SRAM_ADDR = {{(SRAM_ADDR_W-WORD_W){1'b0}}, addr_q};
  assign SRAM_DOUT = wdata_q;
  assign Rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench: three controllers (WAIT_CYCLES = 1, 2, 15) share one stimulus stream.
// Each is compared every cycle against a phase-count model of the access timeline.
// Directed read/write/tie/reset/back-to-back cases, then random traffic with random resets.
module tb_mem_access_ctrl;
  import slc3_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_rd, req_wr;
  logic [15:0] addr, wdata, sram_din;

  logic [15:0] rdata [3];
  logic [19:0] sram_addr [3];
  logic [15:0] sram_dout [3];
  logic        busy [3], done [3], rd_valid [3], drive [3];
  logic        ce_n [3], oe_n [3], we_n [3], ub_n [3], lb_n [3];

  int n_vec = 0;
  int n_err = 0;

  // Model: access phase (0 = idle, 1 = setup, 2..W+1 strobe, W+2 capture/hold, W+3 done).
  int          ph [3];
  bit          m_rd [3];
  logic [15:0] m_addr [3], m_wdata [3], m_rdata [3];

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(Clk), .Reset_n(Reset_n), .Req_Rd(req_rd), .Req_Wr(req_wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata[0]), .Busy(busy[0]), .Done(done[0]), .Rd_Valid(rd_valid[0]),
    .SRAM_ADDR(sram_addr[0]), .SRAM_DOUT(sram_dout[0]), .SRAM_DIN(sram_din), .SRAM_DRIVE(drive[0]),
    .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0]), .SRAM_WE_N(we_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]));

  mem_access_ctrl #(.WAIT_CYCLES(2)) u_w2 (
    .Clk(Clk), .Reset_n(Reset_n), .Req_Rd(req_rd), .Req_Wr(req_wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata[1]), .Busy(busy[1]), .Done(done[1]), .Rd_Valid(rd_valid[1]),
    .SRAM_ADDR(sram_addr[1]), .SRAM_DOUT(sram_dout[1]), .SRAM_DIN(sram_din), .SRAM_DRIVE(drive[1]),
    .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1]), .SRAM_WE_N(we_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]));

  mem_access_ctrl #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Reset_n(Reset_n), .Req_Rd(req_rd), .Req_Wr(req_wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata[2]), .Busy(busy[2]), .Done(done[2]), .Rd_Valid(rd_valid[2]),
    .SRAM_ADDR(sram_addr[2]), .SRAM_DOUT(sram_dout[2]), .SRAM_DIN(sram_din), .SRAM_DRIVE(drive[2]),
    .SRAM_CE_N(ce_n[2]), .SRAM_OE_N(oe_n[2]), .SRAM_WE_N(we_n[2]), .SRAM_UB_N(ub_n[2]), .SRAM_LB_N(lb_n[2]));

  function automatic int wv(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected {Busy, CE_N, OE_N, WE_N, UB_N, LB_N, DRIVE, Done, Rd_Valid} from phase arithmetic.
  function automatic logic [8:0] exp_pins(input int i);
    int  w, p;
    bit  r, bsy, ce, oe, we, drv, dn;
    w   = wv(i);
    p   = ph[i];
    r   = m_rd[i];
    bsy = (p != 0);
    ce  = (p >= 1 && p <= w + 2);
    oe  = r && (p >= 2 && p <= w + 2);
    we  = !r && (p >= 2 && p <= w + 1);
    drv = !r && (p >= 1 && p <= w + 2);
    dn  = (p == w + 3);
    return {bsy, !ce, !oe, !we, !ce, !ce, drv, dn, dn && r};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("w%0d pins", wv(i)),
                {23'd0, busy[i], ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i], drive[i], done[i], rd_valid[i]},
                {23'd0, exp_pins(i)});
      check_val($sformatf("w%0d sram_addr", wv(i)), {12'd0, sram_addr[i]}, {16'd0, m_addr[i]});
      check_val($sformatf("w%0d sram_dout", wv(i)), {16'd0, sram_dout[i]}, {16'd0, m_wdata[i]});
      check_val($sformatf("w%0d rdata", wv(i)), {16'd0, rdata[i]}, {16'd0, m_rdata[i]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; m_rd[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
    end
  endtask

  // Apply what the coming rising edge does to each model, given the inputs now on the pins.
  task automatic model_advance();
    for (int i = 0; i < 3; i++) begin
      if (ph[i] == 0) begin
        if (req_wr) begin
          ph[i] = 1; m_rd[i] = 1'b0; m_addr[i] = addr; m_wdata[i] = wdata;
        end else if (req_rd) begin
          ph[i] = 1; m_rd[i] = 1'b1; m_addr[i] = addr;
        end
      end else begin
        if (m_rd[i] && ph[i] == wv(i) + 2) m_rdata[i] = sram_din;
        ph[i] = (ph[i] == wv(i) + 3) ? 0 : ph[i] + 1;
      end
    end
  endtask

  // Called at a falling edge with inputs already set: one clock, then check.
  task automatic tick();
    model_advance();
    @(negedge Clk);
    check_all();
  endtask

  task automatic idle_ticks(input int n);
    req_rd = 1'b0;
    req_wr = 1'b0;
    for (int k = 0; k < n; k++) begin
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      tick();
    end
  endtask

  // Reset mid-cycle: pins must drop to the reset state before the next edge.
  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    check_all();
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    req_rd   = 1'b0;
    req_wr   = 1'b0;
    addr     = '0;
    wdata    = '0;
    sram_din = '0;
    model_reset();
    #3;
    check_all();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Single read, address 1234, SRAM returns BEEF; Addr changes afterwards to prove latching.
    sram_din = 16'hBEEF;
    req_rd = 1'b1; addr = 16'h1234;
    tick();
    idle_ticks(20);

    // Single write; Rdata must keep BEEF.
    sram_din = 16'h0BAD;
    req_wr = 1'b1; addr = 16'h00FF; wdata = 16'hA5A5;
    tick();
    idle_ticks(20);

    // Read and write together: write wins, OE_N never falls.
    req_rd = 1'b1; req_wr = 1'b1; addr = 16'h4242; wdata = 16'h5A5A;
    tick();
    idle_ticks(20);

    // Reset during the write strobe: no Done, nothing resumes.
    req_wr = 1'b1; addr = 16'h7777; wdata = 16'h1111;
    tick();
    req_wr = 1'b0;
    tick();
    do_reset();
    idle_ticks(20);

    // Continuous read request: back-to-back accesses, nothing accepted while busy.
    req_rd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      addr     = 16'($urandom);
      sram_din = 16'($urandom);
      tick();
    end
    idle_ticks(20);

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(59, 0) == 0) do_reset();
      req_rd   = ($urandom_range(2, 0) == 0);
      req_wr   = ($urandom_range(3, 0) == 0);
      addr     = 16'($urandom);
      wdata    = 16'($urandom);
      sram_din = 16'($urandom);
      tick();
    end
    idle_ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
